// File: rtl/sram_stream_loader.sv
// sram_stream_loader
//   Upstream fill stage for a 2R1W SRAM bank. Packs a valid/ready stream of
//   IN_W-bit words into DATA_W-bit lines (first word in the most significant
//   slot) and writes one line per cycle through the bank's single write port,
//   at addresses base, base+1, ... (wrapping modulo 2^ADDR_W). When the region
//   is full, or the stream ends early, it pulses done together with start_out.
//   start_out comes one cycle after the last line write, so the downstream
//   consumer cannot start before that line is in memory.
//
// Ports
//   clock, reset_n        rising-edge clock, asynchronous active-low reset
//   load_go               one-cycle load request, honoured only in IDLE
//   cfg_base_addr         first line address, captured on an accepted load_go
//   cfg_line_count        number of lines to write, captured with the base
//   in_valid/in_ready     input word handshake
//   in_data, in_last      input word and end-of-stream marker
//   WriteEnable           one-cycle SRAM write strobe per line
//   WriteAddress          SRAM line address; holds its value between writes
//   WriteBus              packed line; holds its value between writes
//   busy                  high from load start through the DONE cycle
//   done, start_out       coincident one-cycle completion pulses
//   err_short             sticky; the stream ended before the region was full
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for load_go
// FILL    | accepting words, writing each line as its last word lands
// LAST_WR | final (or truncated) line is on the write port
// DONE    | done/start_out pulse; back to IDLE next cycle

module sram_stream_loader #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 16,
  parameter int IN_W   = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load_go,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [15:0]       cfg_line_count,
  input  logic              in_valid,
  input  logic [IN_W-1:0]   in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              WriteEnable,
  output logic [ADDR_W-1:0] WriteAddress,
  output logic [DATA_W-1:0] WriteBus,
  output logic              busy,
  output logic              done,
  output logic              start_out,
  output logic              err_short
);

  localparam int WORDS  = DATA_W / IN_W;
  localparam int WIDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] FILL    = 2'd1;
  localparam logic [1:0] LAST_WR = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]        state;
  logic [ADDR_W-1:0] baseAddr;
  logic [15:0]       lineCount;
  logic [15:0]       lineIdx;
  logic [WIDX_W-1:0] wordIdx;
  logic [DATA_W-1:0] packReg;
  logic [DATA_W-1:0] nextPack;

  logic wordAccept;
  logic lineFull;
  logic finalLine;
  logic lineWrite;
  logic endLoad;

  assign in_ready   = (state == FILL);
  assign busy       = (state != IDLE);
  assign wordAccept = in_valid & in_ready;
  assign lineFull   = (wordIdx == WIDX_W'(WORDS - 1));
  assign finalLine  = (lineIdx == lineCount - 16'd1);
  // A line goes out when its last slot fills or the stream ends inside it.
  assign lineWrite  = wordAccept & (lineFull | in_last);
  assign endLoad    = in_last | (lineFull & finalLine);

  // Drop the incoming word into its slot. packReg is cleared after every
  // line write, so slots past the current word are already zero, which is
  // what gives a truncated line its zero fill.
  always_comb begin
    nextPack = packReg;
    for (int i = 0; i < WORDS; i++) begin
      if (wordIdx == WIDX_W'(i)) begin
        nextPack[DATA_W-1-i*IN_W -: IN_W] = in_data;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      baseAddr     <= '0;
      lineCount    <= '0;
      lineIdx      <= '0;
      wordIdx      <= '0;
      packReg      <= '0;
      WriteEnable  <= 1'b0;
      WriteAddress <= '0;
      WriteBus     <= '0;
      done         <= 1'b0;
      start_out    <= 1'b0;
      err_short    <= 1'b0;
    end else begin
      WriteEnable <= 1'b0;
      done        <= 1'b0;
      start_out   <= 1'b0;

      case (state)
        IDLE: begin
          if (load_go) begin
            baseAddr  <= cfg_base_addr;
            lineCount <= cfg_line_count;
            lineIdx   <= '0;
            wordIdx   <= '0;
            packReg   <= '0;
            err_short <= 1'b0;
            if (cfg_line_count == 16'd0) begin
              // Empty region: nothing to write, signal completion at once.
              state     <= DONE;
              done      <= 1'b1;
              start_out <= 1'b1;
            end else begin
              state <= FILL;
            end
          end
        end

        FILL: begin
          if (wordAccept) begin
            if (lineWrite) begin
              WriteEnable  <= 1'b1;
              WriteAddress <= baseAddr + ADDR_W'(lineIdx);
              WriteBus     <= nextPack;
              packReg      <= '0;
              wordIdx      <= '0;
              if (endLoad) begin
                state     <= LAST_WR;
                // Short only if the stream stopped before the last slot
                // of the last line.
                err_short <= ~(lineFull & finalLine);
              end else begin
                lineIdx <= lineIdx + 16'd1;
              end
            end else begin
              packReg <= nextPack;
              wordIdx <= wordIdx + WIDX_W'(1);
            end
          end
        end

        LAST_WR: begin
          state     <= DONE;
          done      <= 1'b1;
          start_out <= 1'b1;
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
